snake_tick_scheduler: RTL and testbench
=======================================

Name: snake_tick_scheduler

Overview:
- Game-speed controller for the snake core. Owns a prescale counter and a seconds counter, and sequences start countdown, run, pause and game-over.
- Emits a single-cycle MOVE_TICK that advances the snake one cell.
- Tick period shortens as the speed level rises; SPEED_UP pulses come from the food/score logic.
- Sits between the button debouncers and the snake position/collision logic.

Parameters:
- PRESCALE_WIDTH, 27, width of the prescale counter and of PERIOD.
- BASE_PERIOD, 25000000, tick period in cycles at level 0 (4 Hz at 100 MHz).
- PERIOD_STEP, 2000000, cycles removed from the period per level.
- MIN_PERIOD, 5000000, floor on the period; must be 2 or more.
- LEVEL_WIDTH, 4, width of LEVEL.
- MAX_LEVEL, 10, saturation value of LEVEL.
- SEC_PERIOD, 100000000, cycles per countdown step.
- CD_START, 3, first countdown value; must be 1 or more.

Ports:
- CLK, input, 1, system clock.
- RESET_N, input, 1, asynchronous active-low reset.
- START, input, 1, single-cycle pulse from a debounced button; starts a new game.
- PAUSE_TOGGLE, input, 1, single-cycle pulse; toggles between RUN and PAUSED.
- SPEED_UP, input, 1, single-cycle pulse; food eaten.
- GAME_OVER, input, 1, single-cycle pulse from collision logic.
- MOVE_TICK, output, 1, single-cycle movement strobe.
- LEVEL, output, LEVEL_WIDTH, current speed level.
- COUNTDOWN_VAL, output, 2, countdown digit for the 7-segment display.
- STATE, output, 3, FSM state: IDLE=0, COUNTDOWN=1, RUN=2, PAUSED=3, OVER=4.
- PERIOD, output, PRESCALE_WIDTH, tick period currently in force.

Behaviour:
- Clock and reset: one clock, CLK. Reset is RESET_N, asynchronous and active-low.
- Reset values: STATE=IDLE, MOVE_TICK=0, LEVEL=0, COUNTDOWN_VAL=0, PERIOD=BASE_PERIOD, prescale=0, seconds counter=0.
- Reset mid-operation: takes effect immediately, with no wait for a clock edge.
- Registering: all outputs are registered. MOVE_TICK is high for exactly 1 cycle.
- Event priority within one cycle: GAME_OVER, then START, then PAUSE_TOGGLE, then SPEED_UP.
- IDLE / OVER:
  - START moves to COUNTDOWN and loads COUNTDOWN_VAL=CD_START.
  - The same edge clears LEVEL, prescale and the seconds counter, and sets PERIOD=BASE_PERIOD.
  - All other inputs are ignored.
- COUNTDOWN:
  - The seconds counter counts 0..SEC_PERIOD-1 and wraps.
  - On each wrap COUNTDOWN_VAL decrements.
  - The wrap that takes it 1->0 also moves to RUN, so COUNTDOWN lasts CD_START*SEC_PERIOD cycles.
  - PAUSE_TOGGLE, SPEED_UP and START are ignored.
  - GAME_OVER moves to OVER.
- RUN, prescale:
  - Prescale increments every cycle.
  - At prescale==PERIOD-1: prescale goes to 0, MOVE_TICK is 1 on the following cycle, and PERIOD reloads from the current LEVEL.
  - Consequences: the first tick is PERIOD cycles after RUN entry, ticks are spaced PERIOD cycles apart, and a level change takes effect at the next wrap only.
- RUN, level and period:
  - SPEED_UP increments LEVEL, saturating at MAX_LEVEL.
  - Period for level L = max(BASE_PERIOD - L*PERIOD_STEP, MIN_PERIOD).
  - The subtraction is done at PRESCALE_WIDTH+1 bits so it cannot underflow; no wrap-around is permitted.
- RUN, other events:
  - PAUSE_TOGGLE moves to PAUSED.
  - GAME_OVER moves to OVER.
  - START is ignored.
- PAUSED:
  - Prescale and PERIOD are frozen, and MOVE_TICK stays 0.
  - PAUSE_TOGGLE returns to RUN, resuming from the held prescale value (no phase loss).
  - SPEED_UP is ignored.
  - GAME_OVER moves to OVER.
- Entering OVER:
  - prescale=0, MOVE_TICK=0.
  - LEVEL is held for the score display.
  - COUNTDOWN_VAL=0.
- Simultaneous events:
  - A tick wrap in the same cycle as GAME_OVER produces no MOVE_TICK.
  - A wrap in the same cycle as PAUSE_TOGGLE still emits MOVE_TICK once; prescale is 0 while paused.
  - SPEED_UP in the same cycle as a wrap is counted, and its new period applies from the following wrap.

Optional Feature:
- Macro: SNAKE_SPEEDUP_EN.
- Defined: LEVEL and period scaling behave as described above.
- Undefined: SPEED_UP is ignored, LEVEL is constant 0, and PERIOD is constant BASE_PERIOD. The level/period arithmetic is not synthesised.

Test Plan:
All scenarios use BASE_PERIOD=10, PERIOD_STEP=2, MIN_PERIOD=4, MAX_LEVEL=10, SEC_PERIOD=5, CD_START=3.
- Reset and START:
  - Stimulus: assert RESET_N=0 for 3 cycles, then release and pulse START.
  - Required: STATE=1. COUNTDOWN_VAL reads 3, 2, 1, each held 5 cycles. STATE=2 after 15 cycles.
- Level-0 tick cadence:
  - Stimulus: stay in RUN at level 0.
  - Required: MOVE_TICK pulses 1 cycle wide, the first 10 cycles after RUN entry, then every 10 cycles.
- Speed-up and clamp:
  - Stimulus: pulse SPEED_UP 3 times.
  - Required: LEVEL=3. PERIOD becomes 4 only after the next wrap. A fourth SPEED_UP gives LEVEL=4 and PERIOD stays 4 (clamped).
- Pause and resume:
  - Stimulus: PAUSE_TOGGLE at prescale=6, wait 50 cycles, then PAUSE_TOGGLE again.
  - Required: no ticks during the pause. The next tick comes 4 cycles after resume (PERIOD=10).
- Collision priority:
  - Stimulus: GAME_OVER in the same cycle as a wrap and a SPEED_UP.
  - Required: STATE=4, no MOVE_TICK, LEVEL unchanged. A subsequent START resets LEVEL to 0.
- Async reset mid-RUN:
  - Stimulus: drop RESET_N between clock edges.
  - Required: STATE=0, LEVEL=0 and MOVE_TICK=0 immediately, before the next CLK edge.
- Macro undefined:
  - Stimulus: 5 SPEED_UP pulses.
  - Required: LEVEL=0, ticks remain every 10 cycles.

Source files
------------

// File: rtl/snake_tick_scheduler.sv
// ---------------------------------------------------------------------------
// snake_tick_scheduler
//
// Game-speed controller for the snake core. Sequences IDLE -> COUNTDOWN ->
// RUN <-> PAUSED -> OVER. While running it divides the clock by PERIOD and
// emits a one-cycle MOVE_TICK per period. The period shortens as the speed
// level rises.
//
// Optional feature macro: SNAKE_SPEEDUP_EN
//   defined   : SPEED_UP raises LEVEL (saturating at MAX_LEVEL), and PERIOD
//               reloads from LEVEL at every tick wrap.
//   undefined : SPEED_UP is ignored, LEVEL is constant 0 and PERIOD is
//               constant BASE_PERIOD. No level/period arithmetic is built.
//
// Ports:
//   CLK           in   system clock
//   RESET_N       in   asynchronous active-low reset
//   START         in   one-cycle pulse, starts a new game from IDLE/OVER
//   PAUSE_TOGGLE  in   one-cycle pulse, toggles RUN <-> PAUSED
//   SPEED_UP      in   one-cycle pulse, food eaten
//   GAME_OVER     in   one-cycle pulse from the collision logic
//   MOVE_TICK     out  one-cycle movement strobe
//   LEVEL         out  current speed level
//   COUNTDOWN_VAL out  countdown digit for the display
//   STATE         out  IDLE=0 COUNTDOWN=1 RUN=2 PAUSED=3 OVER=4
//   PERIOD        out  tick period currently in force, in cycles
// ---------------------------------------------------------------------------
module snake_tick_scheduler #(
    parameter int PRESCALE_WIDTH = 27,
    parameter int BASE_PERIOD    = 25000000,
    parameter int PERIOD_STEP    = 2000000,
    parameter int MIN_PERIOD     = 5000000,
    parameter int LEVEL_WIDTH    = 4,
    parameter int MAX_LEVEL      = 10,
    parameter int SEC_PERIOD     = 100000000,
    parameter int CD_START       = 3
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      START,
    input  logic                      PAUSE_TOGGLE,
    input  logic                      SPEED_UP,
    input  logic                      GAME_OVER,
    output logic                      MOVE_TICK,
    output logic [LEVEL_WIDTH-1:0]    LEVEL,
    output logic [1:0]                COUNTDOWN_VAL,
    output logic [2:0]                STATE,
    output logic [PRESCALE_WIDTH-1:0] PERIOD
);

    localparam int SEC_WIDTH = (SEC_PERIOD > 1) ? $clog2(SEC_PERIOD) : 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_PAUSED    = 3'd3;
    localparam logic [2:0] ST_OVER      = 3'd4;

    localparam logic [PRESCALE_WIDTH-1:0] BASE_P   = PRESCALE_WIDTH'(BASE_PERIOD);
    localparam logic [SEC_WIDTH-1:0]      SEC_LAST = SEC_WIDTH'(SEC_PERIOD - 1);

    logic [2:0]                state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [SEC_WIDTH-1:0]      sec_q, sec_d;
    logic [1:0]                cd_q, cd_d;
    logic                      tick_q, tick_d;

    logic [LEVEL_WIDTH-1:0]    cur_level;
    logic [PRESCALE_WIDTH-1:0] cur_period;

    // Strobes from the sequencer to the level/period block.
    logic load_game;   // START accepted: clear level, restore base period
    logic run_wrap;    // prescale wrapped in RUN: reload period from level
    logic run_speed;   // SPEED_UP accepted in RUN

    logic game_over_hit;
    assign game_over_hit = GAME_OVER && (state_q == ST_COUNTDOWN ||
                                         state_q == ST_RUN ||
                                         state_q == ST_PAUSED);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned, which would infer a latch.
        state_d    = state_q;
        prescale_d = prescale_q;
        sec_d      = sec_q;
        cd_d       = cd_q;
        tick_d     = 1'b0;
        load_game  = 1'b0;
        run_wrap   = 1'b0;
        run_speed  = 1'b0;

        if (game_over_hit) begin
            // Highest priority: swallows any wrap or speed-up this cycle.
            state_d    = ST_OVER;
            prescale_d = '0;
            sec_d      = '0;
            cd_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (START) begin
                        state_d    = ST_COUNTDOWN;
                        cd_d       = 2'(CD_START);
                        prescale_d = '0;
                        sec_d      = '0;
                        load_game  = 1'b1;
                    end
                end
                ST_COUNTDOWN: begin
                    if (sec_q == SEC_LAST) begin
                        sec_d = '0;
                        cd_d  = cd_q - 2'd1;
                        if (cd_q == 2'd1) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        sec_d = sec_q + SEC_WIDTH'(1);
                    end
                end
                ST_RUN: begin
                    // The counter advances even on the cycle that pauses, so
                    // a wrap coinciding with PAUSE_TOGGLE still ticks.
                    if (prescale_q == cur_period - PRESCALE_WIDTH'(1)) begin
                        prescale_d = '0;
                        tick_d     = 1'b1;
                        run_wrap   = 1'b1;
                    end else begin
                        prescale_d = prescale_q + PRESCALE_WIDTH'(1);
                    end
                    if (PAUSE_TOGGLE) begin
                        state_d = ST_PAUSED;
                    end else begin
                        run_speed = SPEED_UP;
                    end
                end
                ST_PAUSED: begin
                    if (PAUSE_TOGGLE) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            prescale_q <= '0;
            sec_q      <= '0;
            cd_q       <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prescale_q <= prescale_d;
            sec_q      <= sec_d;
            cd_q       <= cd_d;
            tick_q     <= tick_d;
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    localparam int PW1 = PRESCALE_WIDTH + 1;
    localparam logic [PW1-1:0]            BASE_X = PW1'(BASE_PERIOD);
    localparam logic [PW1-1:0]            STEP_X = PW1'(PERIOD_STEP);
    localparam logic [PRESCALE_WIDTH-1:0] MIN_P  = PRESCALE_WIDTH'(MIN_PERIOD);
    localparam logic [LEVEL_WIDTH-1:0]    MAX_L  = LEVEL_WIDTH'(MAX_LEVEL);

    logic [LEVEL_WIDTH-1:0]    level_q, level_d;
    logic [PRESCALE_WIDTH-1:0] period_q, period_d;
    logic [PW1-1:0]            step_prod, period_diff;
    logic [PRESCALE_WIDTH-1:0] level_period;

    // One extra bit on the subtraction: a set MSB means the result went
    // negative, which clamps to MIN_PERIOD instead of wrapping.
    always_comb begin
        step_prod   = PW1'(level_q) * STEP_X;
        period_diff = BASE_X - step_prod;
        if (period_diff[PRESCALE_WIDTH] ||
            period_diff[PRESCALE_WIDTH-1:0] < MIN_P) begin
            level_period = MIN_P;
        end else begin
            level_period = period_diff[PRESCALE_WIDTH-1:0];
        end
    end

    // Reload uses the pre-edge level, so a SPEED_UP landing on a wrap only
    // changes the period at the following wrap.
    always_comb begin
        level_d  = level_q;
        period_d = period_q;
        if (load_game) begin
            level_d  = '0;
            period_d = BASE_P;
        end else begin
            if (run_wrap) begin
                period_d = level_period;
            end
            if (run_speed && level_q != MAX_L) begin
                level_d = level_q + LEVEL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            level_q  <= '0;
            period_q <= BASE_P;
        end else begin
            level_q  <= level_d;
            period_q <= period_d;
        end
    end

    assign cur_level  = level_q;
    assign cur_period = period_q;
`else
    assign cur_level  = '0;
    assign cur_period = BASE_P;

    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(PERIOD_STEP) ^ 32'(MIN_PERIOD) ^ 32'(MAX_LEVEL) ^
                        {29'd0, load_game, run_wrap, run_speed ^ SPEED_UP};
`endif

    assign MOVE_TICK     = tick_q;
    assign LEVEL         = cur_level;
    assign COUNTDOWN_VAL = cd_q;
    assign STATE         = state_q;
    assign PERIOD        = cur_period;

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_snake_tick_scheduler
//
// Self-checking bench for snake_tick_scheduler with small parameters
// (BASE_PERIOD=10, PERIOD_STEP=2, MIN_PERIOD=4, MAX_LEVEL=10, SEC_PERIOD=5,
// CD_START=3). A behavioural model tracks the game as "cycles remaining
// until the next tick" and "cycles remaining in this countdown second";
// each scenario task compares the DUT outputs against it.
// ---------------------------------------------------------------------------
module tb_snake_tick_scheduler;

    localparam int PW       = 8;
    localparam int LW       = 4;
    localparam int BASE     = 10;
    localparam int STEP     = 2;
    localparam int MINP     = 4;
    localparam int MAXL     = 10;
    localparam int SEC      = 5;
    localparam int CD_START = 3;

`ifdef SNAKE_SPEEDUP_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    localparam int S_IDLE = 0, S_CD = 1, S_RUN = 2, S_PAUSED = 3, S_OVER = 4;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic          PAUSE_TOGGLE = 1'b0;
    logic          SPEED_UP = 1'b0;
    logic          GAME_OVER = 1'b0;
    logic          MOVE_TICK;
    logic [LW-1:0] LEVEL;
    logic [1:0]    COUNTDOWN_VAL;
    logic [2:0]    STATE;
    logic [PW-1:0] PERIOD;

    int checks = 0;
    int failures = 0;

    snake_tick_scheduler #(
        .PRESCALE_WIDTH(PW), .BASE_PERIOD(BASE), .PERIOD_STEP(STEP),
        .MIN_PERIOD(MINP), .LEVEL_WIDTH(LW), .MAX_LEVEL(MAXL),
        .SEC_PERIOD(SEC), .CD_START(CD_START)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START),
        .PAUSE_TOGGLE(PAUSE_TOGGLE), .SPEED_UP(SPEED_UP),
        .GAME_OVER(GAME_OVER), .MOVE_TICK(MOVE_TICK), .LEVEL(LEVEL),
        .COUNTDOWN_VAL(COUNTDOWN_VAL), .STATE(STATE), .PERIOD(PERIOD)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int m_state, m_level, m_period, m_remain, m_cd, m_sec_left;
    bit m_tick;

    function automatic int period_for(input int lvl);
        int p;
        p = BASE - lvl * STEP;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_level = 0; m_period = BASE; m_remain = BASE;
        m_cd = 0; m_sec_left = SEC; m_tick = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit pt, input bit su, input bit go);
        m_tick = 1'b0;
        if (go && (m_state == S_CD || m_state == S_RUN || m_state == S_PAUSED)) begin
            m_state = S_OVER;
            m_cd = 0;
        end else if (m_state == S_IDLE || m_state == S_OVER) begin
            if (st) begin
                m_state = S_CD; m_cd = CD_START; m_sec_left = SEC;
                m_level = 0; m_period = BASE;
            end
        end else if (m_state == S_CD) begin
            m_sec_left--;
            if (m_sec_left == 0) begin
                m_sec_left = SEC;
                m_cd--;
                if (m_cd == 0) begin
                    m_state = S_RUN;
                    m_remain = m_period;
                end
            end
        end else if (m_state == S_RUN) begin
            m_remain--;
            if (m_remain == 0) begin
                m_tick = 1'b1;
                m_period = period_for(m_level);
                m_remain = m_period;
            end
            if (pt) m_state = S_PAUSED;
            else if (su && EN) m_level = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
        end else if (m_state == S_PAUSED) begin
            if (pt) m_state = S_RUN;
        end
    endtask

    function automatic logic [17:0] exp_vec();
        return {3'(m_state), m_tick, 4'(m_level), 2'(m_cd), 8'(m_period)};
    endfunction

    function automatic logic [17:0] act_vec();
        return {STATE, MOVE_TICK, LEVEL, COUNTDOWN_VAL, PERIOD};
    endfunction

    // Drive one clock cycle: inputs applied at the falling edge, sampled at
    // the rising edge; returns at the next falling edge for comparison.
    task automatic step(input bit st, input bit pt, input bit su, input bit go);
        START = st; PAUSE_TOGGLE = pt; SPEED_UP = su; GAME_OVER = go;
        @(posedge CLK);
        model_step(st, pt, su, go);
        @(negedge CLK);
        START = 1'b0; PAUSE_TOGGLE = 1'b0; SPEED_UP = 1'b0; GAME_OVER = 1'b0;
    endtask

    task automatic restart();
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (CD_START * SEC) step(0, 0, 0, 0);
    endtask

    task automatic wait_remain(input int target, input string tag);
        for (int i = 0; i < 40 && !(m_state == S_RUN && m_remain == target); i++)
            step(0, 0, 0, 0);
        checks++;
        if (!(m_state == S_RUN && m_remain == target)) begin
            failures++;
            $display("FAIL %s: RUN phase %0d not reached (state=%0d remain=%0d)",
                     tag, target, m_state, m_remain);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET_N = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (act_vec() !== {3'd0, 1'b0, 4'd0, 2'd0, 8'd10}) begin
            failures++;
            $display("FAIL reset_state: got %h want %h", act_vec(), {3'd0, 1'b0, 4'd0, 2'd0, 8'd10});
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL after_release: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_countdown();
        step(1, 0, 0, 0);
        checks++;
        if (STATE !== 3'd1 || COUNTDOWN_VAL !== 2'd3) begin
            failures++;
            $display("FAIL start: state=%0d cd=%0d want state=1 cd=3", STATE, COUNTDOWN_VAL);
        end
        for (int i = 1; i <= CD_START * SEC; i++) begin
            // Pause/speed pulses during countdown must be ignored.
            step(0, (i == 3), (i == 7), 0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL countdown cyc=%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (STATE !== 3'd2 || COUNTDOWN_VAL !== 2'd0) begin
            failures++;
            $display("FAIL run_entry: state=%0d cd=%0d want state=2 cd=0", STATE, COUNTDOWN_VAL);
        end
    endtask

    task automatic test_tick_cadence();
        int ticks = 0;
        int last = 0;
        for (int i = 1; i <= 35; i++) begin
            step(0, 0, 0, 0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL cadence cyc=%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (MOVE_TICK === 1'b1) begin
                ticks++;
                checks++;
                if (i - last !== BASE) begin
                    failures++;
                    $display("FAIL tick_spacing: got %0d want %0d", i - last, BASE);
                end
                last = i;
            end
        end
        checks++;
        if (ticks !== 3) begin
            failures++;
            $display("FAIL tick_count: got %0d want 3", ticks);
        end
    endtask

    task automatic test_pause_resume();
        int n;
        wait_remain(4, "pause_setup");
        step(0, 1, 0, 0);
        for (int i = 0; i < 50; i++) begin
            step(0, 0, (i == 10), 0);
            checks++;
            if (MOVE_TICK !== 1'b0 || STATE !== 3'd3 || act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL paused cyc=%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        // The tick arrives on the 4th edge counting the one that samples
        // the resume pulse.
        step(0, 1, 0, 0);
        n = 1;
        while (MOVE_TICK !== 1'b1 && n < 20) begin
            step(0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL resume_latency: got %0d want 4", n);
        end
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL resume_state: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_speed_up();
        int plan[5] = '{2, 2, 25, 20, 25};
        for (int p = 0; p < 5; p++) begin
            step(0, 0, 1, 0);
            for (int i = 0; i < plan[p]; i++) begin
                step(0, 0, 0, 0);
                checks++;
                if (act_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL speed p=%0d cyc=%0d: got %h want %h", p, i, act_vec(), exp_vec());
                end
            end
            if (p == 2) begin
                checks++;
                if (LEVEL !== (EN ? 4'd3 : 4'd0) || PERIOD !== (EN ? 8'd4 : 8'd10)) begin
                    failures++;
                    $display("FAIL level3: level=%0d period=%0d", LEVEL, PERIOD);
                end
            end
        end
        checks++;
        if (LEVEL !== (EN ? 4'd5 : 4'd0) || PERIOD !== (EN ? 8'd4 : 8'd10)) begin
            failures++;
            $display("FAIL clamp: level=%0d period=%0d", LEVEL, PERIOD);
        end
    endtask

    task automatic test_collision();
        int lvl;
        restart();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        wait_remain(1, "collision_setup");
        lvl = m_level;
        step(0, 0, 1, 1);
        checks++;
        if (STATE !== 3'd4 || MOVE_TICK !== 1'b0 || LEVEL !== 4'(lvl) || COUNTDOWN_VAL !== 2'd0) begin
            failures++;
            $display("FAIL collision: state=%0d tick=%0d level=%0d cd=%0d want 4/0/%0d/0",
                     STATE, MOVE_TICK, LEVEL, COUNTDOWN_VAL, lvl);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, (i == 2), (i == 4), 0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL over_hold cyc=%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        step(1, 0, 0, 0);
        checks++;
        if (STATE !== 3'd1 || LEVEL !== 4'd0 || PERIOD !== 8'd10) begin
            failures++;
            $display("FAIL restart: state=%0d level=%0d period=%0d", STATE, LEVEL, PERIOD);
        end
    endtask

    task automatic test_random();
        bit st, pt, su, go;
        restart();
        for (int i = 0; i < 400; i++) begin
            su = ($urandom_range(3) == 0);
            pt = !su && ($urandom_range(15) == 0);
            go = ($urandom_range(80) == 0);
            st = (m_state == S_OVER || m_state == S_IDLE) && ($urandom_range(1) == 0);
            step(st, pt, su, go);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        restart();
        step(0, 0, 1, 0);
        wait_remain(1, "areset_setup");
        step(0, 0, 0, 0);
        checks++;
        if (MOVE_TICK !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre_tick: got %0d want 1", MOVE_TICK);
        end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (STATE !== 3'd0 || LEVEL !== 4'd0 || MOVE_TICK !== 1'b0 ||
            COUNTDOWN_VAL !== 2'd0 || PERIOD !== 8'd10) begin
            failures++;
            $display("FAIL async_reset: got %h want %h", act_vec(), {3'd0, 1'b0, 4'd0, 2'd0, 8'd10});
        end
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
        step(0, 0, 0, 0);
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL post_reset: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_tick_cadence();
        test_pause_resume();
        test_speed_up();
        test_collision();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
